// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one quotient bit per clock.
// Optional DIVIDER_DIV0_EN: divide-by-zero short-circuits to Q=all ones, R=N, err=1.
module seq_divider #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start_i,
   input  logic [W-1:0] n_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o,
   output logic [W-1:0] r_o,
   output logic         busy_o,
   output logic         done_o,
   output logic         err_o
);

   localparam int CW = $clog2(W + 1);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t        state_q, state_d;
   logic [W:0]    rem_q, rem_d;
   logic [W-1:0]  shift_q, shift_d;
   logic [W-1:0]  div_q, div_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  quo_q, quo_d;
   logic [W-1:0]  res_q, res_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   // Bit W of the remainder is always 0 after a restore step; it drops out
   // of the left shift, so it is never read.
   logic          rem_top_unused;

   logic [W:0]    rem_sh;
   logic [W+1:0]  sum;
   logic          no_borrow;
   logic [W:0]    rem_nx;
   logic [W-1:0]  shift_nx;

   assign rem_top_unused = rem_q[W];

   // Trial subtraction in B-A form: carry-out of rem_sh + ~D + 1 means no borrow.
   assign rem_sh    = {rem_q[W-1:0], shift_q[W-1]};
   assign sum       = {1'b0, rem_sh} + {1'b0, ~{1'b0, div_q}} + (W+2)'(1);
   assign no_borrow = sum[W+1];
   assign rem_nx    = no_borrow ? sum[W:0] : rem_sh;
   assign shift_nx  = {shift_q[W-2:0], no_borrow};

`ifdef DIVIDER_DIV0_EN
   logic err_q, err_d;
   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

   assign q_o    = quo_q;
   assign r_o    = res_q;
   assign busy_o = busy_q;
   assign done_o = done_q;

   // Next-state and datapath control for the IDLE/RUN sequencer.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      shift_d = shift_q;
      div_d   = div_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      res_d   = res_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
`ifdef DIVIDER_DIV0_EN
      err_d   = err_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
`ifdef DIVIDER_DIV0_EN
               if (d_i == '0) begin
                  quo_d  = '1;
                  res_d  = n_i;
                  err_d  = 1'b1;
                  done_d = 1'b1;
               end else begin
                  err_d   = 1'b0;
                  div_d   = d_i;
                  rem_d   = '0;
                  shift_d = n_i;
                  cnt_d   = CW'(W);
                  busy_d  = 1'b1;
                  state_d = RUN;
               end
`else
               div_d   = d_i;
               rem_d   = '0;
               shift_d = n_i;
               cnt_d   = CW'(W);
               busy_d  = 1'b1;
               state_d = RUN;
`endif
            end
         end
         RUN: begin
            rem_d   = rem_nx;
            shift_d = shift_nx;
            cnt_d   = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               quo_d   = shift_nx;
               res_d   = rem_nx[W-1:0];
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and result registers; reset clears everything, discarding any partial result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rem_q   <= '0;
         shift_q <= '0;
         div_q   <= '0;
         cnt_q   <= '0;
         quo_q   <= '0;
         res_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef DIVIDER_DIV0_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         shift_q <= shift_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         res_q   <= res_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef DIVIDER_DIV0_EN
         err_q   <= err_d;
`endif
      end
   end

endmodule
